// File: rtl/tile_map_pkg.sv
package tile_map_pkg;

  localparam int unsigned SCREEN_WIDTH  = 480;
  localparam int unsigned SCREEN_HEIGHT = 272;
  localparam int unsigned TILE_WIDTH    = 8;
  localparam int unsigned TILE_HEIGHT   = 8;
  localparam int unsigned TILE_COLUMNS  = SCREEN_WIDTH / TILE_WIDTH;
  localparam int unsigned TILE_ROWS     = SCREEN_HEIGHT / TILE_HEIGHT;
  localparam int unsigned WORDS         = TILE_COLUMNS * TILE_ROWS / 4;
  localparam int unsigned ADDR_W        = 9;
  localparam int unsigned LANE_W        = 8;

  localparam logic OP_PLACE = 1'b0;
  localparam logic OP_FILL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_FILL
  } wr_state_e;

endpackage

// File: rtl/tile_lane_merge.sv
module tile_lane_merge
  import tile_map_pkg::*;
(
  input  logic [31:0]       word,
  input  logic [1:0]        lane,
  input  logic [LANE_W-1:0] tile_byte,
  output logic [31:0]       merged
);

  always_comb begin
    merged = word;
    merged[lane*LANE_W +: LANE_W] = tile_byte;
  end

endmodule

// File: rtl/tile_map_writer.sv
module tile_map_writer
  import tile_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [6:0]        cmd_col,
  input  logic [5:0]        cmd_row,
  input  logic [7:0]        cmd_tile,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              err
);

  wr_state_e   state, state_nxt;
  logic [6:0]  col_q;
  logic [5:0]  row_q;
  logic [7:0]  tile_q;
  logic [1:0]  lane_q;
  logic [10:0] offset;
  logic        in_range;
  logic        fill_last;
  logic [31:0] merged;

  // Only meaningful when in_range; out-of-range products may truncate.
  assign offset    = 11'(row_q) * 11'(TILE_COLUMNS) + 11'(col_q);
  assign in_range  = (32'(col_q) < TILE_COLUMNS) && (32'(row_q) < TILE_ROWS);
  assign fill_last = (32'(mem_addr) == WORDS - 1);

  tile_lane_merge u_merge (
    .word      (mem_rd_data),
    .lane      (lane_q),
    .tile_byte (tile_q),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_op == OP_FILL) ? ST_FILL : ST_CALC;
      end
      ST_CALC: begin
        err       = !in_range;
        state_nxt = in_range ? ST_READ : ST_IDLE;
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_nxt = ST_MERGE;
      end
      ST_MERGE: state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        mem_wr_en = 1'b1;
        if (fill_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = !cmd_ready;

  // mem_addr doubles as the fill counter; it saturates at WORDS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      lane_q      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            col_q  <= cmd_col;
            row_q  <= cmd_row;
            tile_q <= cmd_tile;
            if (cmd_op == OP_FILL) begin
              mem_addr    <= '0;
              mem_wr_data <= {4{cmd_tile}};
            end
          end
        end
        ST_CALC: begin
          if (in_range) begin
            mem_addr <= ADDR_W'(offset[10:2]);
            lane_q   <= offset[1:0];
          end
        end
        ST_MERGE: mem_wr_data <= merged;
        ST_FILL: begin
          if (!fill_last) mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_writer.sv
module tb_tile_map_writer;
  import tile_map_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [6:0]        cmd_col = '0;
  logic [5:0]        cmd_row = '0;
  logic [7:0]        cmd_tile = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              busy;
  logic              err;

  tile_map_writer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_col     (cmd_col),
    .cmd_row     (cmd_row),
    .cmd_tile    (cmd_tile),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         mon_e;
  logic [31:0] ram     [WORDS];
  logic [31:0] exp_mem [WORDS];
  logic [31:0] rd_data_q = '0;
  logic        preload = 1'b1;
  int unsigned edge_n = 0;
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  assign mem_rd_data = rd_data_q;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0)  return 32'h0302_0100;
    if (i == 15) return 32'h1122_3344;
    return 32'h5000_0000 + 32'(i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Synchronous RAM model for the write-side port.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (preload) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_rd_en) rd_data_q <= ram[mem_addr];
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (err) err_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      if (sb_q.size() == 0) check_eq("wr_unexpected", 32'(sb_q.size()), 32'd1);
      else begin
        mon_e = sb_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check_eq("wr_data", mem_wr_data, mon_e.data);
      end
    end
  end

  task automatic push_place(input int unsigned col, input int unsigned row, input logic [7:0] tile);
    int unsigned off, a, lane;
    logic [31:0] d;
    if (col < TILE_COLUMNS && row < TILE_ROWS) begin
      off  = row * TILE_COLUMNS + col;
      a    = off / 4;
      lane = off % 4;
      d    = exp_mem[a];
      d[lane*8 +: 8] = tile;
      exp_mem[a] = d;
      sb_q.push_back('{addr: ADDR_W'(a), data: d});
    end
  endtask

  task automatic wait_ready(input int unsigned budget, input string tag);
    int unsigned w = 0;
    while (!cmd_ready && w < budget) begin
      @(negedge clk);
      w++;
    end
    check_eq(tag, 32'(cmd_ready), 32'd1);
  endtask

  // Returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic op, input int unsigned col, input int unsigned row,
                       input logic [7:0] tile, output int unsigned acc);
    @(negedge clk);
    cmd_op    = op;
    cmd_col   = 7'(col);
    cmd_row   = 6'(row);
    cmd_tile  = tile;
    cmd_valid = 1'b1;
    wait_ready(20, "issue_ready");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = edge_n;
  endtask

  task automatic check_place_timing(input string tag, input int unsigned addr, input logic [31:0] data);
    check_eq({tag, "_c1_rd"}, 32'(mem_rd_en), 32'd0);
    check_eq({tag, "_c1_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({tag, "_c2_rd"}, 32'(mem_rd_en), 32'd1);
    check_eq({tag, "_c2_addr"}, 32'(mem_addr), 32'(addr));
    @(negedge clk);
    check_eq({tag, "_c3_rd"}, 32'(mem_rd_en), 32'd0);
    check_eq({tag, "_c3_wr"}, 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    check_eq({tag, "_c4_wr"}, 32'(mem_wr_en), 32'd1);
    check_eq({tag, "_c4_addr"}, 32'(mem_addr), 32'(addr));
    check_eq({tag, "_c4_data"}, mem_wr_data, data);
    @(negedge clk);
    check_eq({tag, "_c5_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_c5_wr"}, 32'(mem_wr_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned accs [3];
    int unsigned w0, r0, e0, w;
    int unsigned t5_col [3] = '{4, 5, 59};
    int unsigned t5_row [3] = '{0, 0, 33};
    logic [7:0]  t5_tile [3] = '{8'h1E, 8'h2D, 8'h3C};

    for (int i = 0; i < WORDS; i++) exp_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    preload = 1'b0;

    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd", 32'(mem_rd_en), 32'd0);
    check_eq("rst_wr", 32'(mem_wr_en), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wr_data, 32'd0);
    rst = 1'b0;

    // 1: first field of the screen
    push_place(0, 0, 8'h05);
    issue(OP_PLACE, 0, 0, 8'h05, acc);
    check_place_timing("t1", 0, 32'h0302_0105);

    // 2: offset 63 -> word 15, lane 3
    push_place(3, 1, 8'hA7);
    issue(OP_PLACE, 3, 1, 8'hA7, acc);
    check_place_timing("t2", 15, 32'hA722_3344);

    // 3: out-of-range column and row
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    issue(OP_PLACE, 60, 0, 8'h11, acc);
    check_eq("t3a_err", 32'(err), 32'd1);
    @(negedge clk);
    check_eq("t3a_err_off", 32'(err), 32'd0);
    check_eq("t3a_ready", 32'(cmd_ready), 32'd1);
    issue(OP_PLACE, 0, 34, 8'h22, acc);
    check_eq("t3b_err", 32'(err), 32'd1);
    @(negedge clk);
    check_eq("t3b_err_off", 32'(err), 32'd0);
    check_eq("t3b_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t3_wr_cnt", wr_cnt - w0, 32'd0);
    check_eq("t3_rd_cnt", rd_cnt - r0, 32'd0);
    check_eq("t3_err_cnt", err_cnt - e0, 32'd2);

    // 4: fill whole screen
    for (int i = 0; i < WORDS; i++) begin
      exp_mem[i] = 32'h0101_0101;
      sb_q.push_back('{addr: ADDR_W'(i), data: 32'h0101_0101});
    end
    w0 = wr_cnt; r0 = rd_cnt;
    issue(OP_FILL, 0, 0, 8'h01, acc);
    check_eq("t4_first_wr", 32'(mem_wr_en), 32'd1);
    check_eq("t4_first_addr", 32'(mem_addr), 32'd0);
    wait_ready(WORDS + 20, "t4_done");
    check_eq("t4_wr_cnt", wr_cnt - w0, 32'(WORDS));
    check_eq("t4_rd_cnt", rd_cnt - r0, 32'd0);
    check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5: three PLACEs with cmd_valid held high
    for (int i = 0; i < 3; i++) push_place(t5_col[i], t5_row[i], t5_tile[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmd_op    = OP_PLACE;
      cmd_col   = 7'(t5_col[i]);
      cmd_row   = 6'(t5_row[i]);
      cmd_tile  = t5_tile[i];
      cmd_valid = 1'b1;
      wait_ready(20, "t5_ready");
      @(posedge clk);
      @(negedge clk);
      accs[i] = edge_n;
    end
    cmd_valid = 1'b0;
    wait_ready(20, "t5_done");
    check_eq("t5_gap1", accs[1] - accs[0], 32'd5);
    check_eq("t5_gap2", accs[2] - accs[1], 32'd5);
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: reset during a fill; words from 100 up keep their contents
    for (int i = 0; i < 100; i++) begin
      exp_mem[i] = 32'h5A5A_5A5A;
      sb_q.push_back('{addr: ADDR_W'(i), data: 32'h5A5A_5A5A});
    end
    w0 = wr_cnt;
    issue(OP_FILL, 0, 0, 8'h5A, acc);
    w = 0;
    while (!(mem_wr_en && mem_addr == ADDR_W'(99)) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq("t6_at99", 32'(mem_addr), 32'd99);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_wr", 32'(mem_wr_en), 32'd0);
    check_eq("t6_rst_rd", 32'(mem_rd_en), 32'd0);
    check_eq("t6_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("t6_rst_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_rst_wdata", mem_wr_data, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t6_wr_cnt", wr_cnt - w0, 32'd100);
    check_eq("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < WORDS; i++) check_eq("t6_mem", ram[i], exp_mem[i]);

    push_place(2, 30, 8'hC3);
    issue(OP_PLACE, 2, 30, 8'hC3, acc);
    check_place_timing("t6p", 450, 32'h01C3_0101);

    repeat (2) @(negedge clk);
    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("final_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
